// File: rtl/up_script_pkg.sv
// Shared definitions for the ROM-scripted up_* bus master: entry layout, opcodes, error codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package up_script_pkg;

  localparam int ENTRY_W = 67;

  // Entry layout {op, addr, data}
  localparam int OP_HI   = 66;
  localparam int OP_LO   = 64;
  localparam int ADDR_HI = 63;
  localparam int ADDR_LO = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  localparam logic [2:0] OP_END      = 3'd0;
  localparam logic [2:0] OP_WRITE    = 3'd1;
  localparam logic [2:0] OP_READ     = 3'd2;
  localparam logic [2:0] OP_POLL_SET = 3'd3;
  localparam logic [2:0] OP_POLL_CLR = 3'd4;
  localparam logic [2:0] OP_DELAY    = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_POLL    = 2'd1;
  localparam logic [1:0] ERR_TMO     = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_BUS, ST_GAP, ST_PGAP, ST_DELAY, ST_DONE, ST_ERR
  } state_t;

  function automatic logic [2:0] entry_op(input logic [ENTRY_W-1:0] e);
    return e[OP_HI:OP_LO];
  endfunction

  function automatic logic [31:0] entry_addr(input logic [ENTRY_W-1:0] e);
    return e[ADDR_HI:ADDR_LO];
  endfunction

  function automatic logic [31:0] entry_data(input logic [ENTRY_W-1:0] e);
    return e[DATA_HI:DATA_LO];
  endfunction

endpackage

// File: rtl/up_script_master.sv
// ROM-scripted up_* bus master: fetch/decode 67-bit entries, run WRITE/READ/POLL/DELAY/END.
// Latency: 4 cycles per WRITE/READ entry with up_wait=0 (FETCH, DECODE, BUS, GAP); ROM read is 1 cycle.
// Backpressure: strobe/addr/data held while up_wait=1; optional abort after BUS_TMO cycles (UP_BUS_TIMEOUT_EN).
module up_script_master
  import up_script_pkg::*;
#(
  parameter int ROM_AW   = 8,
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 16,
  parameter int BUS_TMO  = 4096
) (
  input  logic                up_clk,
  input  logic                ext_reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [ROM_AW-1:0]   err_pc,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [ENTRY_W-1:0]  rom_data,
  output logic                up_wr,
  output logic                up_rd,
  output logic [31:0]         up_addr,
  output logic [31:0]         up_data_wr,
  input  logic [31:0]         up_data_rd,
  input  logic                up_wait,
  output logic [31:0]         last_rd
);

  // A zero gap would need the strobe to stay high across polls; one idle cycle is the minimum.
  localparam int          PGAP_EFF = (POLL_GAP < 1) ? 1 : POLL_GAP;
  localparam logic [31:0] PGAP_LD  = 32'(PGAP_EFF - 1);
  localparam logic [31:0] PMAX_C   = 32'(POLL_MAX);

  state_t              state_q;
  logic [ROM_AW-1:0]   pc_q;
  logic [2:0]          op_q;
  logic [31:0]         data_q;
  logic [31:0]         att_q;
  logic [31:0]         cnt_q;
  logic                up_wr_q, up_rd_q;
  logic [31:0]         up_addr_q, up_data_wr_q, last_rd_q;
  logic                busy_q, done_q, error_q;
  logic [1:0]          err_code_q;
  logic [ROM_AW-1:0]   err_pc_q;
`ifdef UP_BUS_TIMEOUT_EN
  localparam logic [31:0] TMO_LIM = 32'(BUS_TMO - 1);
  logic [31:0]         tmo_q;
`endif

  logic [ROM_AW-1:0]   pc_inc_d;
  logic                last_entry_d;
  logic                xfer_d;
  logic                is_poll_d;
  logic                poll_ok_d;
  logic [31:0]         att_inc_d;
  logic [31:0]         rd_mask_d;

  // Next-entry address, transfer completion and poll condition on the current read data
  always_comb begin
    pc_inc_d     = pc_q + ROM_AW'(1);
    last_entry_d = &pc_q;
    xfer_d       = (up_wr_q | up_rd_q) & ~up_wait;
    is_poll_d    = (op_q == OP_POLL_SET) || (op_q == OP_POLL_CLR);
    rd_mask_d    = up_data_rd & data_q;
    poll_ok_d    = (op_q == OP_POLL_CLR) ? (rd_mask_d == 32'h0) : (rd_mask_d == data_q);
    att_inc_d    = (att_q == 32'hFFFF_FFFF) ? att_q : att_q + 32'd1;
  end

  // Script sequencer with registered bus strobes and status flags
  always_ff @(posedge up_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      op_q         <= OP_END;
      data_q       <= '0;
      att_q        <= '0;
      cnt_q        <= '0;
      up_wr_q      <= 1'b0;
      up_rd_q      <= 1'b0;
      up_addr_q    <= '0;
      up_data_wr_q <= '0;
      last_rd_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_pc_q     <= '0;
`ifdef UP_BUS_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b1;
            pc_q       <= '0;
            state_q    <= ST_FETCH;
          end
        end
        // rom_addr (= pc) is presented for this cycle; data is usable in DECODE
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          op_q   <= entry_op(rom_data);
          data_q <= entry_data(rom_data);
          att_q  <= '0;
          case (entry_op(rom_data))
            OP_END: begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
            OP_WRITE: begin
              up_wr_q      <= 1'b1;
              up_addr_q    <= entry_addr(rom_data);
              up_data_wr_q <= entry_data(rom_data);
              state_q      <= ST_BUS;
            end
            OP_READ, OP_POLL_SET, OP_POLL_CLR: begin
              up_rd_q   <= 1'b1;
              up_addr_q <= entry_addr(rom_data);
              state_q   <= ST_BUS;
            end
            OP_DELAY: begin
              if (entry_data(rom_data) == 32'h0) begin
                if (last_entry_d) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
                end else begin
                  pc_q    <= pc_inc_d;
                  state_q <= ST_FETCH;
                end
              end else begin
                cnt_q   <= entry_data(rom_data) - 32'd1;
                state_q <= ST_DELAY;
              end
            end
            default: begin
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
              err_code_q <= ERR_ILLEGAL;
              err_pc_q   <= pc_q;
              state_q    <= ST_ERR;
            end
          endcase
        end
        ST_BUS: begin
          if (xfer_d) begin
            up_wr_q <= 1'b0;
            up_rd_q <= 1'b0;
`ifdef UP_BUS_TIMEOUT_EN
            tmo_q   <= '0;
`endif
            if (up_rd_q) last_rd_q <= up_data_rd;
            if (is_poll_d && !poll_ok_d) begin
              att_q <= att_inc_d;
              if (att_inc_d >= PMAX_C) begin
                busy_q     <= 1'b0;
                error_q    <= 1'b1;
                err_code_q <= ERR_POLL;
                err_pc_q   <= pc_q;
                state_q    <= ST_ERR;
              end else begin
                cnt_q   <= PGAP_LD;
                state_q <= ST_PGAP;
              end
            end else begin
              state_q <= ST_GAP;
            end
          end
`ifdef UP_BUS_TIMEOUT_EN
          else if (tmo_q == TMO_LIM) begin
            up_wr_q    <= 1'b0;
            up_rd_q    <= 1'b0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_TMO;
            err_pc_q   <= pc_q;
            state_q    <= ST_ERR;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
`endif
        end
        ST_GAP: begin
          if (last_entry_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            pc_q    <= pc_inc_d;
            state_q <= ST_FETCH;
          end
        end
        ST_PGAP: begin
          if (cnt_q == 32'h0) begin
            up_rd_q <= 1'b1;
            state_q <= ST_BUS;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        ST_DELAY: begin
          if (cnt_q != 32'h0) begin
            cnt_q <= cnt_q - 32'd1;
          end else if (last_entry_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            pc_q    <= pc_inc_d;
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign err_pc     = err_pc_q;
  assign rom_addr   = pc_q;
  assign up_wr      = up_wr_q;
  assign up_rd      = up_rd_q;
  assign up_addr    = up_addr_q;
  assign up_data_wr = up_data_wr_q;
  assign last_rd    = last_rd_q;

endmodule

// File: tb/tb_up_script_master.sv
// Bench for up_script_master: scripted ROM, stalling slave, interpreter-style reference model.
// Latency: checks entry timing in cycles from the start pulse.
// Backpressure: slave inserts directed, random or permanent up_wait stalls.
module tb_up_script_master;
  import up_script_pkg::*;

  localparam int AW    = 4;
  localparam int NENT  = 16;
  localparam int PMAX  = 4;
  localparam int PGAP  = 3;
  localparam int TMO   = 40;
  localparam int BOUND = 3000;

  logic        up_clk = 1'b0;
  logic        ext_reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [AW-1:0] err_pc, rom_addr;
  logic [66:0] rom_data = '0;
  logic        up_wr, up_rd;
  logic [31:0] up_addr, up_data_wr, last_rd;
  logic [31:0] up_data_rd = '0;
  logic        up_wait = 1'b0;

  up_script_master #(.ROM_AW(AW), .POLL_MAX(PMAX), .POLL_GAP(PGAP), .BUS_TMO(TMO)) dut (
    .up_clk(up_clk), .ext_reset_n(ext_reset_n), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .err_pc(err_pc), .rom_addr(rom_addr), .rom_data(rom_data),
    .up_wr(up_wr), .up_rd(up_rd), .up_addr(up_addr), .up_data_wr(up_data_wr),
    .up_data_rd(up_data_rd), .up_wait(up_wait), .last_rd(last_rd)
  );

  always #5 up_clk = ~up_clk;

  // Script ROM with one-cycle registered read
  logic [66:0] rom [NENT];
  always @(posedge up_clk) rom_data <= rom[rom_addr];

  // Slave / monitor state
  int          total = 0, bad = 0;
  int          stall_mode = 0, wait_hold = 0;
  logic [31:0] rd_vals [128];
  int          rd_idx = 0;
  logic [64:0] obs_q [$];
  int          lo_runs [$];
  int          hi_run = 0, lo_run = 0, last_hi_len = 0, excl_viol = 0, consec = 0;
  logic        w;

  // Expected results from the model
  logic [64:0] exp_q [$];
  logic        exp_done, exp_err;
  logic [1:0]  exp_code;
  int          exp_pc;
  logic [31:0] exp_last = '0;

  // Slave decides up_wait for the coming edge and logs transfers that will complete on it
  always @(negedge up_clk) begin
    if (up_wr && up_rd) excl_viol++;
    up_data_rd = rd_vals[rd_idx % 128];
    if (up_wr || up_rd) begin
      if (hi_run == 0) lo_runs.push_back(lo_run);
      case (stall_mode)
        0:       w = 1'b0;
        1:       w = (consec < 3) && ($urandom_range(2) == 0);
        2:       w = (hi_run < wait_hold);
        default: w = 1'b1;
      endcase
      up_wait = w;
      consec  = w ? consec + 1 : 0;
      hi_run++;
      last_hi_len = hi_run;
      lo_run = 0;
      if (!w) begin
        obs_q.push_back({up_rd, up_addr, up_rd ? up_data_rd : up_data_wr});
        if (up_rd) rd_idx++;
      end
    end else begin
      up_wait = 1'b0;
      hi_run  = 0;
      consec  = 0;
      lo_run++;
    end
  end

  function automatic logic [66:0] ent(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    return {op, a, d};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < NENT; i++) rom[i] = ent(OP_END, 32'h0, 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge up_clk);
    ext_reset_n = 1'b0;
    stall_mode  = 0;
    repeat (2) @(negedge up_clk);
    ext_reset_n = 1'b1;
    exp_last    = '0;
    @(negedge up_clk);
  endtask

  // Pulse start and wait (bounded) for done or error; lat = cycle index of the first strobe
  task automatic run_script(input int stall, output int lat);
    int cyc;
    stall_mode = stall;
    obs_q.delete();
    lo_runs.delete();
    rd_idx = 0;
    @(negedge up_clk); start = 1'b1;
    @(negedge up_clk); start = 1'b0;
    lat = -1;
    cyc = 1;
    while (!(done || error) && cyc < BOUND) begin
      @(negedge up_clk);
      cyc++;
      if (lat < 0 && (up_wr || up_rd)) lat = cyc;
    end
  endtask

  // Interpret the ROM script directly against the slave's planned read values
  task automatic model_run();
    int k, pc;
    bit fin, ok;
    logic [2:0]  op;
    logic [31:0] a, d, v;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_code = 0; exp_pc = 0;
    k = 0; pc = 0; fin = 0;
    while (!fin) begin
      op = rom[pc][66:64]; a = rom[pc][63:32]; d = rom[pc][31:0];
      case (op)
        3'd0: begin exp_done = 1; fin = 1; end
        3'd1: exp_q.push_back({1'b0, a, d});
        3'd2: begin v = rd_vals[k % 128]; k++; exp_q.push_back({1'b1, a, v}); exp_last = v; end
        3'd3, 3'd4: begin
          ok = 0;
          for (int t = 1; t <= PMAX && !ok; t++) begin
            v = rd_vals[k % 128]; k++;
            exp_q.push_back({1'b1, a, v});
            exp_last = v;
            ok = (op == 3'd3) ? ((v & d) == d) : ((v & d) == 0);
          end
          if (!ok) begin exp_err = 1; exp_code = 2'd1; exp_pc = pc; fin = 1; end
        end
        3'd5: ;
        default: begin exp_err = 1; exp_code = 2'd3; exp_pc = pc; fin = 1; end
      endcase
      if (!fin) begin
        if (pc == NENT - 1) begin exp_done = 1; fin = 1; end
        else pc++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge up_clk);
    total++;
    if ({busy, done, error, err_code, err_pc, rom_addr, up_wr, up_rd} !== '0) begin
      $display("FAIL reset_ctrl got busy=%b done=%b error=%b code=%0d pc=%0d addr=%0d wr=%b rd=%b want all 0",
               busy, done, error, err_code, err_pc, rom_addr, up_wr, up_rd);
      bad++;
    end
    total++;
    if ({up_addr, up_data_wr, last_rd} !== 96'h0) begin
      $display("FAIL reset_data got addr=%h wdata=%h last_rd=%h want 0", up_addr, up_data_wr, last_rd);
      bad++;
    end
    ext_reset_n = 1'b1;
    @(negedge up_clk);
  endtask

  task automatic test_write();
    int lat;
    clear_rom();
    rom[0] = ent(OP_WRITE, 32'h8, 32'h3);
    run_script(0, lat);
    total++;
    if (lat !== 3) begin $display("FAIL write_latency got %0d want 3", lat); bad++; end
    total++;
    if (obs_q.size() !== 1 || obs_q[0] !== {1'b0, 32'h8, 32'h3}) begin
      $display("FAIL write_xfer got n=%0d first=%h want 1 x %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 65'h0, {1'b0, 32'h8, 32'h3});
      bad++;
    end
    total++;
    if (last_hi_len !== 1) begin $display("FAIL write_pulse got %0d want 1", last_hi_len); bad++; end
    total++;
    if ({busy, done, error} !== 3'b010) begin
      $display("FAIL write_flags got busy=%b done=%b error=%b want 0 1 0", busy, done, error); bad++;
    end
  endtask

  task automatic test_read_stall();
    int lat;
    clear_rom();
    rom[0] = ent(OP_READ, 32'hC, 32'h0);
    rd_vals[0] = 32'hDEADBEEF;
    wait_hold = 5;
    run_script(2, lat);
    total++;
    if (last_hi_len !== 6) begin $display("FAIL read_strobe_len got %0d want 6", last_hi_len); bad++; end
    total++;
    if (last_rd !== 32'hDEADBEEF) begin $display("FAIL read_last_rd got %h want deadbeef", last_rd); bad++; end
    total++;
    if (obs_q.size() !== 1 || obs_q[0] !== {1'b1, 32'hC, 32'hDEADBEEF} || done !== 1'b1) begin
      $display("FAIL read_xfer got n=%0d done=%b want 1 read of 0xC, done=1", obs_q.size(), done); bad++;
    end
    stall_mode = 0;
  endtask

  task automatic test_poll_set();
    int lat;
    clear_rom();
    rom[0] = ent(OP_POLL_SET, 32'h10, 32'h4);
    rd_vals[0] = $urandom() & ~32'h4;
    rd_vals[1] = $urandom() & ~32'h4;
    rd_vals[2] = $urandom() | 32'h4;
    run_script(0, lat);
    total++;
    if (obs_q.size() !== 3) begin $display("FAIL poll_set_reads got %0d want 3", obs_q.size()); bad++; end
    total++;
    if (lo_runs.size() < 3 || lo_runs[1] !== PGAP || lo_runs[2] !== PGAP) begin
      $display("FAIL poll_set_gap got n=%0d g1=%0d g2=%0d want %0d", lo_runs.size(),
               (lo_runs.size() > 1) ? lo_runs[1] : -1, (lo_runs.size() > 2) ? lo_runs[2] : -1, PGAP);
      bad++;
    end
    total++;
    if ({done, error} !== 2'b10 || last_rd !== rd_vals[2]) begin
      $display("FAIL poll_set_end got done=%b error=%b last_rd=%h want 1 0 %h", done, error, last_rd, rd_vals[2]);
      bad++;
    end
  endtask

  task automatic test_poll_limit();
    int lat;
    clear_rom();
    rom[0] = ent(OP_WRITE, 32'h4, 32'h1);
    rom[1] = ent(OP_POLL_CLR, 32'h20, 32'h1);
    for (int i = 0; i < 8; i++) rd_vals[i] = $urandom() | 32'h1;
    run_script(0, lat);
    total++;
    if (obs_q.size() !== 1 + PMAX) begin $display("FAIL poll_limit_reads got %0d want %0d", obs_q.size(), 1 + PMAX); bad++; end
    total++;
    if ({done, error, err_code} !== 4'b0101 || err_pc !== 4'd1) begin
      $display("FAIL poll_limit_err got done=%b error=%b code=%0d pc=%0d want 0 1 1 1", done, error, err_code, err_pc);
      bad++;
    end
  endtask

  task automatic test_illegal_restart();
    int lat, cyc;
    clear_rom();
    rom[0] = ent(OP_WRITE, 32'h100, 32'h11);
    rom[1] = ent(OP_WRITE, 32'h104, 32'h22);
    rom[2] = ent(3'd7, 32'h108, 32'h33);
    run_script(0, lat);
    total++;
    if (obs_q.size() !== 2 || error !== 1'b1 || err_code !== 2'd3 || err_pc !== 4'd2) begin
      $display("FAIL illegal_err got n=%0d error=%b code=%0d pc=%0d want 2 1 3 2", obs_q.size(), error, err_code, err_pc);
      bad++;
    end
    @(negedge up_clk); start = 1'b1;
    @(negedge up_clk); start = 1'b0;
    total++;
    if ({busy, error, err_code} !== 4'b1000) begin
      $display("FAIL restart_clear got busy=%b error=%b code=%0d want 1 0 0", busy, error, err_code); bad++;
    end
    cyc = 0;
    while (!error && cyc < BOUND) begin @(negedge up_clk); cyc++; end
    total++;
    if (obs_q.size() !== 4 || obs_q[2] !== {1'b0, 32'h100, 32'h11} || err_code !== 2'd3) begin
      $display("FAIL restart_rerun got n=%0d code=%0d want 4 writes code 3", obs_q.size(), err_code); bad++;
    end
  endtask

  task automatic test_delay();
    int lat;
    clear_rom();
    rom[0] = ent(OP_DELAY, 32'h0, 32'd5);
    rom[1] = ent(OP_WRITE, 32'h30, 32'h5);
    run_script(0, lat);
    total++;
    if (lat !== 10) begin $display("FAIL delay5_latency got %0d want 10", lat); bad++; end
    rom[0] = ent(OP_DELAY, 32'h0, 32'd0);
    run_script(0, lat);
    total++;
    if (lat !== 5 || done !== 1'b1) begin $display("FAIL delay0_latency got %0d done=%b want 5 1", lat, done); bad++; end
  endtask

  task automatic test_start_busy();
    int lat, cyc;
    clear_rom();
    rom[0] = ent(OP_DELAY, 32'h0, 32'd20);
    rom[1] = ent(OP_WRITE, 32'h40, 32'h7);
    obs_q.delete();
    @(negedge up_clk); start = 1'b1;
    @(negedge up_clk); start = 1'b0;
    lat = -1; cyc = 1;
    while (!(done || error) && cyc < BOUND) begin
      @(negedge up_clk);
      cyc++;
      start = (cyc == 5);
      if (lat < 0 && up_wr) lat = cyc;
    end
    start = 1'b0;
    total++;
    if (lat !== 25 || obs_q.size() !== 1) begin
      $display("FAIL start_while_busy got lat=%0d n=%0d want 25 1", lat, obs_q.size()); bad++;
    end
  endtask

  task automatic test_wrap();
    int lat;
    for (int i = 0; i < NENT; i++) rom[i] = ent(OP_WRITE, 32'(i), ~32'(i));
    run_script(0, lat);
    total++;
    if (obs_q.size() !== NENT || obs_q[NENT-1] !== {1'b0, 32'(NENT-1), ~32'(NENT-1)}) begin
      $display("FAIL wrap_writes got n=%0d want %0d", obs_q.size(), NENT); bad++;
    end
    total++;
    if ({busy, done, error} !== 3'b010) begin
      $display("FAIL wrap_done got busy=%b done=%b error=%b want 0 1 0", busy, done, error); bad++;
    end
  endtask

  task automatic test_random();
    int lat, r;
    logic [2:0] op;
    apply_reset();
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < NENT; i++) begin
        r = $urandom_range(99);
        if (r < 30)      op = OP_WRITE;
        else if (r < 50) op = OP_READ;
        else if (r < 65) op = OP_POLL_SET;
        else if (r < 80) op = OP_POLL_CLR;
        else if (r < 88) op = OP_DELAY;
        else if (r < 95) op = OP_END;
        else             op = 3'(6 + $urandom_range(1));
        if (op == OP_DELAY)
          rom[i] = ent(op, $urandom(), 32'($urandom_range(6)));
        else if (op == OP_POLL_SET || op == OP_POLL_CLR)
          rom[i] = ent(op, $urandom(), 32'h1 << $urandom_range(1));
        else
          rom[i] = ent(op, $urandom(), $urandom());
      end
      for (int i = 0; i < 128; i++) rd_vals[i] = $urandom();
      model_run();
      run_script(1, lat);
      total++;
      if (obs_q.size() !== exp_q.size()) begin
        $display("FAIL rand%0d_count got %0d want %0d", it, obs_q.size(), exp_q.size()); bad++;
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          $display("FAIL rand%0d_xfer%0d got %h want %h", it, i, obs_q[i], exp_q[i]); bad++;
        end
      end
      total++;
      if ({busy, done, error} !== {1'b0, exp_done, exp_err} || last_rd !== exp_last) begin
        $display("FAIL rand%0d_status got busy=%b done=%b error=%b last_rd=%h want 0 %b %b %h",
                 it, busy, done, error, last_rd, exp_done, exp_err, exp_last);
        bad++;
      end
      if (exp_err) begin
        total++;
        if (err_code !== exp_code || err_pc !== AW'(exp_pc)) begin
          $display("FAIL rand%0d_err got code=%0d pc=%0d want %0d %0d", it, err_code, err_pc, exp_code, exp_pc);
          bad++;
        end
      end
    end
    stall_mode = 0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_rom();
    rom[0] = ent(OP_READ, 32'h44, 32'h0);
    stall_mode = 3;
    @(negedge up_clk); start = 1'b1;
    @(negedge up_clk); start = 1'b0;
    cyc = 0;
    while (!up_rd && cyc < 50) begin @(negedge up_clk); cyc++; end
    repeat (3) @(negedge up_clk);
    total++;
    if (up_rd !== 1'b1) begin $display("FAIL mid_reset_setup got up_rd=%b want 1", up_rd); bad++; end
    ext_reset_n = 1'b0;
    #1;
    total++;
    if ({up_rd, up_wr, busy, up_addr} !== 35'h0) begin
      $display("FAIL mid_reset_drop got rd=%b wr=%b busy=%b addr=%h want 0", up_rd, up_wr, busy, up_addr); bad++;
    end
    @(negedge up_clk);
    ext_reset_n = 1'b1;
    stall_mode  = 0;
    exp_last    = '0;
    @(negedge up_clk);
  endtask

`ifdef UP_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    clear_rom();
    rom[0] = ent(OP_READ, 32'h50, 32'h0);
    rom[1] = ent(OP_WRITE, 32'h54, 32'h1);
    run_script(3, lat);
    total++;
    if ({error, err_code} !== 3'b110 || err_pc !== 4'd0 || up_rd !== 1'b0) begin
      $display("FAIL timeout_err got error=%b code=%0d pc=%0d rd=%b want 1 2 0 0", error, err_code, err_pc, up_rd);
      bad++;
    end
    total++;
    if (last_hi_len !== TMO || obs_q.size() !== 0) begin
      $display("FAIL timeout_len got %0d n=%0d want %0d 0", last_hi_len, obs_q.size(), TMO); bad++;
    end
    stall_mode = 0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) rd_vals[i] = '0;
    clear_rom();
    test_reset();
    test_write();
    test_read_stall();
    test_poll_set();
    test_poll_limit();
    test_illegal_restart();
    test_delay();
    test_start_busy();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef UP_BUS_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (excl_viol !== 0) begin $display("FAIL strobe_exclusive got %0d overlaps want 0", excl_viol); bad++; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
